// File: rtl/cache_axi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cache_axi_arbiter_pkg
//  Brief   : Shared types and helpers for the ICache/DCache AXI arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
package cache_axi_arbiter_pkg;

    localparam int ADDR_BITS = 32;
    localparam int LINE_BITS = 128;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ICACHE = 2'd1,
        R_DCACHE = 2'd2
    } ArbReadStateType;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } ArbWriteStateType;

    typedef enum logic [0:0] {
        ARB_ICACHE = 1'b0,
        ARB_DCACHE = 1'b1
    } ArbOwnerType;

    // Tie-break between two eligible requesters: alternate in RR mode, else DCache.
    function automatic ArbOwnerType rr_pick(input ArbOwnerType last, input logic rr_en);
        if (rr_en && (last == ARB_DCACHE))
            return ARB_ICACHE;
        return ARB_DCACHE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_bus_interface.sv
`default_nettype none
// ============================================================================
//  Module  : AXI_Bus_Interface
//  Brief   : Cache-line refill/writeback channel between caches and AXI bridge.
//  Revision: 1.0 - initial release
// ============================================================================
interface AXI_Bus_Interface;
    import cache_axi_arbiter_pkg::*;

    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_rdy;
    logic                 ret_valid;
    logic [LINE_BITS-1:0] ret_data;
    logic                 wr_req;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [LINE_BITS-1:0] wr_data;
    logic                 wr_rdy;
    logic                 wr_valid;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid
    );

endinterface
`default_nettype wire

// File: rtl/cache_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : cache_axi_arbiter
//  Brief   : Shares one line refill/writeback channel between ICache and DCache.
//  Revision: 1.0 - initial release
// ============================================================================
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter int OFFSET_BITS = 4,
    parameter bit RR_ENABLE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    AXI_Bus_Interface.slave         icache_bus,
    AXI_Bus_Interface.slave         dcache_bus,
    AXI_Bus_Interface.master        axi_bus,
    output logic                    arb_busy
);

    localparam int LINE_ADDR_BITS = ADDR_BITS - OFFSET_BITS;

    ArbReadStateType             r_rd_state;
    ArbReadStateType             w_rd_state_nxt;
    ArbWriteStateType            r_wr_state;
    ArbWriteStateType            w_wr_state_nxt;
    ArbOwnerType                 r_last_grant;
    logic [LINE_ADDR_BITS-1:0]   r_wb_line;

    logic [LINE_ADDR_BITS-1:0]   w_rd_line;
    logic [LINE_ADDR_BITS-1:0]   w_wr_line;
    logic                        w_raw_hold;

    logic                        w_i_elig;
    logic                        w_d_elig;
    ArbOwnerType                 w_grant;
    logic                        w_rd_hs;
    logic                        w_axi_rd_req;
    logic [ADDR_BITS-1:0]        w_axi_rd_addr;
    logic                        w_i_rd_rdy;
    logic                        w_d_rd_rdy;
    logic                        w_i_ret_valid;
    logic                        w_d_ret_valid;

    logic                        w_wr_hs;
    logic                        w_axi_wr_req;
    logic                        w_d_wr_rdy;
    logic                        w_d_wr_valid;
    logic                        w_unused;

    assign w_rd_line = dcache_bus.rd_addr[ADDR_BITS-1:OFFSET_BITS];
    assign w_wr_line = dcache_bus.wr_addr[ADDR_BITS-1:OFFSET_BITS];

    // A DCache refill must not overtake a writeback of the same line.
    always_comb begin : raw_cmp
        w_raw_hold = 1'b0;
        if ((r_wr_state == W_BUSY) && (w_rd_line == r_wb_line))
            w_raw_hold = 1'b1;
        if (dcache_bus.wr_req && (w_rd_line == w_wr_line))
            w_raw_hold = 1'b1;
    end

    always_comb begin : rd_fsm
        w_rd_state_nxt = r_rd_state;
        w_rd_hs        = 1'b0;
        w_axi_rd_req   = 1'b0;
        w_axi_rd_addr  = '0;
        w_i_rd_rdy     = 1'b0;
        w_d_rd_rdy     = 1'b0;
        w_i_ret_valid  = 1'b0;
        w_d_ret_valid  = 1'b0;
        w_i_elig       = icache_bus.rd_req;
        w_d_elig       = dcache_bus.rd_req && !w_raw_hold;
        w_grant        = ARB_ICACHE;
        if (w_i_elig && w_d_elig)
            w_grant = rr_pick(r_last_grant, RR_ENABLE);
        else if (w_d_elig)
            w_grant = ARB_DCACHE;

        case (r_rd_state)
            R_IDLE: begin
                if (w_i_elig || w_d_elig) begin
                    w_axi_rd_req = 1'b1;
                    if (w_grant == ARB_ICACHE) begin
                        w_axi_rd_addr = icache_bus.rd_addr;
                        w_i_rd_rdy    = axi_bus.rd_rdy;
                    end else begin
                        w_axi_rd_addr = dcache_bus.rd_addr;
                        w_d_rd_rdy    = axi_bus.rd_rdy;
                    end
                    if (axi_bus.rd_rdy) begin
                        w_rd_hs = 1'b1;
                        if (w_grant == ARB_ICACHE)
                            w_rd_state_nxt = R_ICACHE;
                        else
                            w_rd_state_nxt = R_DCACHE;
                    end
                end
            end
            R_ICACHE: begin
                w_i_ret_valid = axi_bus.ret_valid;
                if (axi_bus.ret_valid)
                    w_rd_state_nxt = R_IDLE;
            end
            R_DCACHE: begin
                w_d_ret_valid = axi_bus.ret_valid;
                if (axi_bus.ret_valid)
                    w_rd_state_nxt = R_IDLE;
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin : wr_fsm
        w_wr_state_nxt = r_wr_state;
        w_wr_hs        = 1'b0;
        w_axi_wr_req   = 1'b0;
        w_d_wr_rdy     = 1'b0;
        w_d_wr_valid   = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                w_axi_wr_req = dcache_bus.wr_req;
                w_d_wr_rdy   = axi_bus.wr_rdy;
                if (dcache_bus.wr_req && axi_bus.wr_rdy) begin
                    w_wr_hs        = 1'b1;
                    w_wr_state_nxt = W_BUSY;
                end
            end
            W_BUSY: begin
                w_d_wr_valid = axi_bus.wr_valid;
                if (axi_bus.wr_valid)
                    w_wr_state_nxt = W_IDLE;
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state   <= R_IDLE;
            r_wr_state   <= W_IDLE;
            r_last_grant <= ARB_DCACHE;
            r_wb_line    <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_wr_state <= w_wr_state_nxt;
            if (w_rd_hs)
                r_last_grant <= w_grant;
            if (w_wr_hs)
                r_wb_line <= w_wr_line;
        end
    end

    // Handshake outputs are forced low for the whole time reset is asserted.
    assign axi_bus.rd_req       = w_axi_rd_req & ~rst;
    assign axi_bus.rd_addr      = w_axi_rd_addr;
    assign axi_bus.wr_req       = w_axi_wr_req & ~rst;
    assign axi_bus.wr_addr      = dcache_bus.wr_addr;
    assign axi_bus.wr_data      = dcache_bus.wr_data;

    assign icache_bus.rd_rdy    = w_i_rd_rdy & ~rst;
    assign icache_bus.ret_valid = w_i_ret_valid & ~rst;
    assign icache_bus.ret_data  = axi_bus.ret_data;
    assign icache_bus.wr_rdy    = 1'b0;
    assign icache_bus.wr_valid  = 1'b0;

    assign dcache_bus.rd_rdy    = w_d_rd_rdy & ~rst;
    assign dcache_bus.ret_valid = w_d_ret_valid & ~rst;
    assign dcache_bus.ret_data  = axi_bus.ret_data;
    assign dcache_bus.wr_rdy    = w_d_wr_rdy & ~rst;
    assign dcache_bus.wr_valid  = w_d_wr_valid & ~rst;

    assign arb_busy = (r_rd_state != R_IDLE) || (r_wr_state != W_IDLE);

    assign w_unused = ^{icache_bus.wr_req, icache_bus.wr_addr, icache_bus.wr_data};

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cache_axi_arbiter
//  Brief   : Directed self-checking bench for cache_axi_arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_cache_axi_arbiter;

    logic clk;
    logic rst;
    logic arb_busy;
    logic fp_busy;
    int   checks;
    int   errors;

    AXI_Bus_Interface icache_if();
    AXI_Bus_Interface dcache_if();
    AXI_Bus_Interface axi_if();
    AXI_Bus_Interface fi_if();
    AXI_Bus_Interface fd_if();
    AXI_Bus_Interface fa_if();

    cache_axi_arbiter #(.OFFSET_BITS(4), .RR_ENABLE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .icache_bus (icache_if.slave),
        .dcache_bus (dcache_if.slave),
        .axi_bus    (axi_if.master),
        .arb_busy   (arb_busy)
    );

    cache_axi_arbiter #(.OFFSET_BITS(4), .RR_ENABLE(1'b0)) dut_fp (
        .clk        (clk),
        .rst        (rst),
        .icache_bus (fi_if.slave),
        .dcache_bus (fd_if.slave),
        .axi_bus    (fa_if.master),
        .arb_busy   (fp_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        icache_if.rd_req = 1'b0; icache_if.rd_addr = '0;
        icache_if.wr_req = 1'b0; icache_if.wr_addr = '0; icache_if.wr_data = '0;
        dcache_if.rd_req = 1'b0; dcache_if.rd_addr = '0;
        dcache_if.wr_req = 1'b0; dcache_if.wr_addr = '0; dcache_if.wr_data = '0;
        axi_if.rd_rdy = 1'b0; axi_if.ret_valid = 1'b0; axi_if.ret_data = '0;
        axi_if.wr_rdy = 1'b0; axi_if.wr_valid = 1'b0;
    endtask

    task automatic idle_fp_inputs();
        fi_if.rd_req = 1'b0; fi_if.rd_addr = '0;
        fi_if.wr_req = 1'b0; fi_if.wr_addr = '0; fi_if.wr_data = '0;
        fd_if.rd_req = 1'b0; fd_if.rd_addr = '0;
        fd_if.wr_req = 1'b0; fd_if.wr_addr = '0; fd_if.wr_data = '0;
        fa_if.rd_rdy = 1'b0; fa_if.ret_valid = 1'b0; fa_if.ret_data = '0;
        fa_if.wr_rdy = 1'b0; fa_if.wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Completes one ICache read so that the round-robin pointer points at ICache.
    task automatic icache_read(input logic [31:0] addr);
        icache_if.rd_req = 1'b1; icache_if.rd_addr = addr; axi_if.rd_rdy = 1'b1;
        step();
        icache_if.rd_req = 1'b0; axi_if.ret_valid = 1'b1;
        step();
        axi_if.ret_valid = 1'b0; axi_if.rd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        icache_if.rd_req = 1'b1; icache_if.rd_addr = 32'h0000_0100;
        dcache_if.wr_req = 1'b1;
        axi_if.rd_rdy = 1'b1; axi_if.wr_rdy = 1'b1;
        axi_if.ret_valid = 1'b1; axi_if.wr_valid = 1'b1;
        #1;
        checks++; if (axi_if.rd_req !== 1'b0) begin errors++; $display("FAIL reset_axi_rd_req: got %b want 0", axi_if.rd_req); end
        checks++; if (axi_if.wr_req !== 1'b0) begin errors++; $display("FAIL reset_axi_wr_req: got %b want 0", axi_if.wr_req); end
        checks++; if (icache_if.rd_rdy !== 1'b0) begin errors++; $display("FAIL reset_i_rd_rdy: got %b want 0", icache_if.rd_rdy); end
        checks++; if (dcache_if.wr_rdy !== 1'b0) begin errors++; $display("FAIL reset_d_wr_rdy: got %b want 0", dcache_if.wr_rdy); end
        checks++; if (icache_if.ret_valid !== 1'b0) begin errors++; $display("FAIL reset_i_ret_valid: got %b want 0", icache_if.ret_valid); end
        checks++; if (dcache_if.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_d_wr_valid: got %b want 0", dcache_if.wr_valid); end
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_arb_busy: got %b want 0", arb_busy); end
        step();
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_icache_read();
        int i_cnt;
        int d_cnt;
        i_cnt = 0;
        d_cnt = 0;
        icache_if.rd_req = 1'b1; icache_if.rd_addr = 32'h1fc0_0010; axi_if.rd_rdy = 1'b1;
        #1;
        checks++; if (axi_if.rd_req !== 1'b1) begin errors++; $display("FAIL t1_axi_rd_req: got %b want 1", axi_if.rd_req); end
        checks++; if (axi_if.rd_addr !== 32'h1fc0_0010) begin errors++; $display("FAIL t1_axi_rd_addr: got %h want 1fc00010", axi_if.rd_addr); end
        checks++; if (icache_if.rd_rdy !== 1'b1) begin errors++; $display("FAIL t1_i_rd_rdy: got %b want 1", icache_if.rd_rdy); end
        checks++; if (dcache_if.rd_rdy !== 1'b0) begin errors++; $display("FAIL t1_d_rd_rdy: got %b want 0", dcache_if.rd_rdy); end
        step();
        icache_if.rd_req = 1'b0;
        axi_if.ret_data = {16{8'hA5}};
        for (int k = 1; k <= 5; k++) begin
            axi_if.ret_valid = (k == 5);
            #1;
            if (icache_if.ret_valid === 1'b1) i_cnt++;
            if (dcache_if.ret_valid !== 1'b0) d_cnt++;
            if (k == 1) begin
                checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", arb_busy); end
            end
            if (k == 5) begin
                checks++; if (icache_if.ret_data !== {16{8'hA5}}) begin errors++; $display("FAIL t1_ret_data: got %h want a5..a5", icache_if.ret_data); end
            end
            step();
        end
        axi_if.ret_valid = 1'b0;
        #1;
        checks++; if (i_cnt != 1) begin errors++; $display("FAIL t1_i_ret_count: got %0d want 1", i_cnt); end
        checks++; if (d_cnt != 0) begin errors++; $display("FAIL t1_d_ret_count: got %0d want 0", d_cnt); end
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %b want 0", arb_busy); end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic        exp_i;
        logic [31:0] exp_addr;
        do_reset();
        icache_if.rd_req = 1'b1; icache_if.rd_addr = 32'h0000_1000;
        dcache_if.rd_req = 1'b1; dcache_if.rd_addr = 32'h0000_2000;
        axi_if.rd_rdy = 1'b1;
        for (int g = 0; g < 6; g++) begin
            exp_i    = (g % 2 == 0);
            exp_addr = exp_i ? 32'h0000_1000 : 32'h0000_2000;
            #1;
            checks++; if (axi_if.rd_addr !== exp_addr) begin errors++; $display("FAIL rr_addr[%0d]: got %h want %h", g, axi_if.rd_addr, exp_addr); end
            checks++; if (icache_if.rd_rdy !== exp_i) begin errors++; $display("FAIL rr_i_rdy[%0d]: got %b want %b", g, icache_if.rd_rdy, exp_i); end
            checks++; if (dcache_if.rd_rdy !== !exp_i) begin errors++; $display("FAIL rr_d_rdy[%0d]: got %b want %b", g, dcache_if.rd_rdy, !exp_i); end
            step();
            axi_if.ret_valid = 1'b1;
            #1;
            checks++; if (axi_if.rd_req !== 1'b0) begin errors++; $display("FAIL rr_owner_rd_req[%0d]: got %b want 0", g, axi_if.rd_req); end
            checks++; if ((icache_if.rd_rdy | dcache_if.rd_rdy) !== 1'b0) begin errors++; $display("FAIL rr_owner_rdy[%0d]: got %b%b want 00", g, icache_if.rd_rdy, dcache_if.rd_rdy); end
            checks++; if (icache_if.ret_valid !== exp_i) begin errors++; $display("FAIL rr_i_ret[%0d]: got %b want %b", g, icache_if.ret_valid, exp_i); end
            checks++; if (dcache_if.ret_valid !== !exp_i) begin errors++; $display("FAIL rr_d_ret[%0d]: got %b want %b", g, dcache_if.ret_valid, !exp_i); end
            step();
            axi_if.ret_valid = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        fi_if.rd_req = 1'b1; fi_if.rd_addr = 32'h0000_1000;
        fd_if.rd_req = 1'b1; fd_if.rd_addr = 32'h0000_2000;
        fa_if.rd_rdy = 1'b1;
        for (int g = 0; g < 3; g++) begin
            #1;
            checks++; if (fa_if.rd_addr !== 32'h0000_2000) begin errors++; $display("FAIL fp_addr[%0d]: got %h want 00002000", g, fa_if.rd_addr); end
            checks++; if (fd_if.rd_rdy !== 1'b1 || fi_if.rd_rdy !== 1'b0) begin errors++; $display("FAIL fp_rdy[%0d]: got i=%b d=%b want i=0 d=1", g, fi_if.rd_rdy, fd_if.rd_rdy); end
            step();
            fa_if.ret_valid = 1'b1;
            step();
            fa_if.ret_valid = 1'b0;
        end
        idle_fp_inputs();
    endtask

    task automatic test_raw_hold();
        do_reset();
        dcache_if.wr_req = 1'b1; dcache_if.wr_addr = 32'h0000_1230;
        dcache_if.wr_data = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
        axi_if.wr_rdy = 1'b1;
        #1;
        checks++; if (axi_if.wr_req !== 1'b1) begin errors++; $display("FAIL raw_axi_wr_req: got %b want 1", axi_if.wr_req); end
        checks++; if (axi_if.wr_addr !== 32'h0000_1230) begin errors++; $display("FAIL raw_axi_wr_addr: got %h want 00001230", axi_if.wr_addr); end
        checks++; if (dcache_if.wr_rdy !== 1'b1) begin errors++; $display("FAIL raw_d_wr_rdy: got %b want 1", dcache_if.wr_rdy); end
        step();
        dcache_if.wr_req = 1'b0;
        dcache_if.rd_req = 1'b1; dcache_if.rd_addr = 32'h0000_1234;
        axi_if.rd_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            axi_if.wr_valid = (k == 8);
            #1;
            checks++; if (axi_if.rd_req !== 1'b0) begin errors++; $display("FAIL raw_held[%0d]: got rd_req=%b want 0", k, axi_if.rd_req); end
            if (k == 8) begin
                checks++; if (dcache_if.wr_valid !== 1'b1) begin errors++; $display("FAIL raw_d_wr_valid: got %b want 1", dcache_if.wr_valid); end
            end
            step();
        end
        axi_if.wr_valid = 1'b0;
        #1;
        checks++; if (axi_if.rd_req !== 1'b1 || axi_if.rd_addr !== 32'h0000_1234) begin errors++; $display("FAIL raw_release: got req=%b addr=%h want req=1 addr=00001234", axi_if.rd_req, axi_if.rd_addr); end
        checks++; if (dcache_if.rd_rdy !== 1'b1) begin errors++; $display("FAIL raw_release_rdy: got %b want 1", dcache_if.rd_rdy); end
        step();
        dcache_if.rd_req = 1'b0; axi_if.ret_valid = 1'b1;
        #1;
        checks++; if (dcache_if.ret_valid !== 1'b1) begin errors++; $display("FAIL raw_d_ret: got %b want 1", dcache_if.ret_valid); end
        step();
        axi_if.ret_valid = 1'b0;
        dcache_if.wr_req = 1'b1; dcache_if.wr_addr = 32'h0000_1230;
        step();
        dcache_if.wr_req = 1'b0;
        dcache_if.rd_req = 1'b1; dcache_if.rd_addr = 32'h0000_2230;
        #1;
        checks++; if (axi_if.rd_req !== 1'b1 || axi_if.rd_addr !== 32'h0000_2230) begin errors++; $display("FAIL raw_other_line: got req=%b addr=%h want req=1 addr=00002230", axi_if.rd_req, axi_if.rd_addr); end
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL raw_busy_wr: got %b want 1", arb_busy); end
        step();
        dcache_if.rd_req = 1'b0; axi_if.ret_valid = 1'b1; axi_if.wr_valid = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_concurrent();
        do_reset();
        icache_read(32'h0000_0400);
        icache_if.rd_req = 1'b1; icache_if.rd_addr = 32'h0000_0400;
        dcache_if.wr_req = 1'b1; dcache_if.wr_addr = 32'h0000_0080;
        dcache_if.rd_req = 1'b1; dcache_if.rd_addr = 32'h0000_0084;
        axi_if.rd_rdy = 1'b1; axi_if.wr_rdy = 1'b1;
        #1;
        checks++; if (axi_if.wr_req !== 1'b1 || dcache_if.wr_rdy !== 1'b1) begin errors++; $display("FAIL cc_write: got req=%b rdy=%b want 1 1", axi_if.wr_req, dcache_if.wr_rdy); end
        checks++; if (axi_if.rd_addr !== 32'h0000_0400) begin errors++; $display("FAIL cc_rd_addr: got %h want 00000400", axi_if.rd_addr); end
        checks++; if (icache_if.rd_rdy !== 1'b1 || dcache_if.rd_rdy !== 1'b0) begin errors++; $display("FAIL cc_rd_rdy: got i=%b d=%b want i=1 d=0", icache_if.rd_rdy, dcache_if.rd_rdy); end
        step();
        icache_if.rd_req = 1'b0; dcache_if.wr_req = 1'b0; axi_if.ret_valid = 1'b1;
        #1;
        checks++; if (icache_if.ret_valid !== 1'b1) begin errors++; $display("FAIL cc_i_ret: got %b want 1", icache_if.ret_valid); end
        step();
        axi_if.ret_valid = 1'b0; axi_if.wr_valid = 1'b1;
        #1;
        checks++; if (axi_if.rd_req !== 1'b0) begin errors++; $display("FAIL cc_held: got %b want 0", axi_if.rd_req); end
        checks++; if (dcache_if.wr_valid !== 1'b1) begin errors++; $display("FAIL cc_wr_valid: got %b want 1", dcache_if.wr_valid); end
        step();
        axi_if.wr_valid = 1'b0;
        #1;
        checks++; if (axi_if.rd_req !== 1'b1 || axi_if.rd_addr !== 32'h0000_0084 || dcache_if.rd_rdy !== 1'b1) begin errors++; $display("FAIL cc_release: got req=%b addr=%h rdy=%b want 1 00000084 1", axi_if.rd_req, axi_if.rd_addr, dcache_if.rd_rdy); end
        step();
        dcache_if.rd_req = 1'b0; axi_if.ret_valid = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        dcache_if.rd_req = 1'b1; dcache_if.rd_addr = 32'h0000_3000; axi_if.rd_rdy = 1'b1;
        step();
        dcache_if.rd_req = 1'b0;
        #1;
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL mr_busy_before: got %b want 1", arb_busy); end
        rst = 1'b1; axi_if.ret_valid = 1'b1;
        #1;
        checks++; if (dcache_if.ret_valid !== 1'b0 || icache_if.ret_valid !== 1'b0) begin errors++; $display("FAIL mr_ret_in_reset: got i=%b d=%b want 0 0", icache_if.ret_valid, dcache_if.ret_valid); end
        checks++; if (arb_busy !== 1'b0 || axi_if.rd_req !== 1'b0) begin errors++; $display("FAIL mr_outputs: got busy=%b rd_req=%b want 0 0", arb_busy, axi_if.rd_req); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (dcache_if.ret_valid !== 1'b0) begin errors++; $display("FAIL mr_late_ret: got %b want 0", dcache_if.ret_valid); end
        step();
        axi_if.ret_valid = 1'b0;
        icache_if.rd_req = 1'b1; icache_if.rd_addr = 32'h0000_0500;
        #1;
        checks++; if (axi_if.rd_req !== 1'b1 || axi_if.rd_addr !== 32'h0000_0500 || icache_if.rd_rdy !== 1'b1) begin errors++; $display("FAIL mr_first_grant: got req=%b addr=%h rdy=%b want 1 00000500 1", axi_if.rd_req, axi_if.rd_addr, icache_if.rd_rdy); end
        step();
        icache_if.rd_req = 1'b0; axi_if.ret_valid = 1'b1;
        #1;
        checks++; if (icache_if.ret_valid !== 1'b1) begin errors++; $display("FAIL mr_i_ret: got %b want 1", icache_if.ret_valid); end
        step();
        idle_inputs();
    endtask

    task automatic test_rdy_low();
        logic [31:0] exp_addr;
        do_reset();
        icache_read(32'h0000_0700);
        icache_if.rd_req = 1'b1; icache_if.rd_addr = 32'h0000_0700;
        axi_if.rd_rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c >= 4) begin
                dcache_if.rd_req = 1'b1; dcache_if.rd_addr = 32'h0000_0600;
            end
            exp_addr = (c >= 4) ? 32'h0000_0600 : 32'h0000_0700;
            #1;
            checks++; if (axi_if.rd_req !== 1'b1 || axi_if.rd_addr !== exp_addr) begin errors++; $display("FAIL rl_fwd[%0d]: got req=%b addr=%h want 1 %h", c, axi_if.rd_req, axi_if.rd_addr, exp_addr); end
            checks++; if (icache_if.rd_rdy !== 1'b0 || arb_busy !== 1'b0) begin errors++; $display("FAIL rl_idle[%0d]: got rdy=%b busy=%b want 0 0", c, icache_if.rd_rdy, arb_busy); end
            step();
        end
        axi_if.rd_rdy = 1'b1;
        #1;
        checks++; if (dcache_if.rd_rdy !== 1'b1 || icache_if.rd_rdy !== 1'b0) begin errors++; $display("FAIL rl_grant: got i=%b d=%b want i=0 d=1", icache_if.rd_rdy, dcache_if.rd_rdy); end
        step();
        #1;
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL rl_busy: got %b want 1", arb_busy); end
        icache_if.rd_req = 1'b0; dcache_if.rd_req = 1'b0; axi_if.ret_valid = 1'b1;
        #1;
        checks++; if (dcache_if.ret_valid !== 1'b1) begin errors++; $display("FAIL rl_d_ret: got %b want 1", dcache_if.ret_valid); end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_inputs();
        idle_fp_inputs();
        step();
        test_reset();
        test_icache_read();
        test_round_robin();
        test_fixed_priority();
        test_raw_hold();
        test_concurrent();
        test_reset_midflight();
        test_rdy_low();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
